channel_decoder: RTL and testbench

Receive-side end of the simple-encoding channel. Accepts 10-bit encoded words (7 data bits plus a 3-bit checksum) from the channel through a valid/ready handshake. It recomputes the checksum, buffers good data in a small FIFO and counts corrupted words. It sits between the channel output and the data consumer, mirroring the encoder that builds `{data[6:0], checksum[2:0]}`.

---
 rtl/simple_enc_pkg.sv | 24 ++
 rtl/dec_fifo.sv | 49 ++++
 rtl/channel_decoder.sv | 100 ++++++++++
 tb/tb_channel_decoder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_enc_pkg.sv
// Shared definitions for the simple-encoding channel: word layout and the
// popcount checksum used by both encoder and decoder.
package simple_enc_pkg;

  localparam int DATA_W = 7;
  localparam int CSUM_W = 3;
  localparam int WORD_W = DATA_W + CSUM_W;

  localparam int DATA_HI = WORD_W - 1;
  localparam int DATA_LO = CSUM_W;
  localparam int CSUM_HI = CSUM_W - 1;
  localparam int CSUM_LO = 0;

  // Number of set bits in the data field; 7 bits never exceed 3-bit range.
  function automatic logic [CSUM_W-1:0] calc_csum(input logic [DATA_W-1:0] d);
    logic [CSUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + CSUM_W'(d[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/dec_fifo.sv
// Circular-buffer FIFO with explicit count register; head entry is shown
// directly from storage (no bypass of a push into an empty FIFO).
module dec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/channel_decoder.sv
// Receive end of the simple-encoding channel: capture, checksum check, FIFO,
// saturating error counter. Define DEC_PASS_BAD_EN to forward bad words tagged.
module channel_decoder
  import simple_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              out_ready,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  input  logic              clr_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef DEC_PASS_BAD_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif

  // Handshake: a transfer occurs on a rising edge where valid && ready are
  // both high; valid never waits on ready, and ready depends only on state.
  logic              s1_valid;
  logic [WORD_W-1:0] s1_word;
  logic              csum_ok;
  logic              bad;
  logic              push;
  logic              pop;
  logic [FW-1:0]     push_data;
  logic [FW-1:0]     head;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;

  assign csum_ok = (s1_word[CSUM_HI:CSUM_LO] == calc_csum(s1_word[DATA_HI:DATA_LO]));
  assign bad     = s1_valid && !csum_ok;

  // A word sitting in stage 1 reserves a FIFO slot, so no overflow is possible.
  assign occ      = {1'b0, fifo_count} + (CW+1)'(s1_valid);
  assign in_ready = (occ < (CW+1)'(DEPTH));

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign err_pulse = bad;

`ifdef DEC_PASS_BAD_EN
  assign push      = s1_valid;
  assign push_data = {bad, s1_word[DATA_HI:DATA_LO]};
  assign out_data  = head[DATA_W-1:0];
  assign out_err   = head[DATA_W];
`else
  assign push      = s1_valid && csum_ok;
  assign push_data = s1_word[DATA_HI:DATA_LO];
  assign out_data  = head;
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) s1_word <= in_word;
    end
  end

  // Clear wins over a same-cycle increment; count holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (bad && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  dec_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

endmodule

// File: tb/tb_channel_decoder.sv
// Self-checking bench for channel_decoder (default build): scoreboard of
// expected data, per-scenario tasks, single summary line.
module tb_channel_decoder;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_word = '0;
  logic       out_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] out_data;
  logic       out_err;
  logic       err_pulse;
  logic [ERR_W-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit rand_ready = 1'b0;
  logic [6:0] exp_q[$];

  channel_decoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .clr_cnt   (clr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] mk_good(input logic [6:0] d);
    return {d, 3'($countones(d))};
  endfunction

  function automatic logic [9:0] mk_bad(input logic [6:0] d);
    return {d, 3'($countones(d)) + 3'd1};
  endfunction

  function automatic bit is_good(input logic [9:0] w);
    logic [6:0] d;
    d = w[9:3];
    return w[2:0] == 3'($countones(d));
  endfunction

  // One clock cycle: scoreboard check mid-cycle, then step past the edge.
  task automatic tick();
    logic [6:0] exp;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data %h, expected no output", out_data);
      end else begin
        exp = exp_q.pop_front();
        n_out++;
        if (out_data !== exp || out_err !== 1'b0) begin
          n_fail++;
          $display("FAIL scoreboard: got data %h err %b, expected data %h err 0", out_data, out_err, exp);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [9:0] w);
    bit r;
    bit done;
    int budget;
    done = 0;
    budget = 0;
    r = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!done) begin
      r = in_ready;
      tick();
      if (r) done = 1;
      else begin
        budget++;
        if (budget > 100) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", budget);
          done = 1;
        end
      end
    end
    if (r && is_good(w)) exp_q.push_back(w[9:3]);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 300) begin
      tick();
      c++;
    end
    n_checks++;
    if (exp_q.size() != 0 || out_valid) begin
      n_fail++;
      $display("FAIL drain: %0d words still expected, out_valid %b, expected 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_pulse !== 1'b0 ||
        err_cnt !== '0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got ov %b ir %b ep %b cnt %0d oe %b, expected 0 1 0 0 0",
               out_valid, in_ready, err_pulse, err_cnt, out_err);
    end
  endtask

  task automatic test_single_good();
    out_ready = 1'b1;
    send_word(10'h2CC);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_cycle1: got out_valid %b, expected 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h59) begin
      n_fail++;
      $display("FAIL latency_cycle2: got ov %b data %h, expected 1 59", out_valid, out_data);
    end
    n_checks++;
    if (err_cnt !== '0) begin
      n_fail++;
      $display("FAIL good_err_cnt: got %0d, expected 0", err_cnt);
    end
    wait_drain();
  endtask

  task automatic test_bad_word();
    out_ready = 1'b1;
    send_word(10'h2CD);
    n_checks++;
    if (err_pulse !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_cycle1: got ep %b ov %b, expected 1 0", err_pulse, out_valid);
    end
    tick();
    n_checks++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_cycle2: got ep %b cnt %0d ov %b, expected 0 1 0", err_pulse, err_cnt, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] words [5];
    int k;
    bit r;
    words[0] = 10'h000;
    words[1] = 10'h3FF;
    words[2] = 10'h2CC;
    words[3] = mk_good(7'h15);
    words[4] = mk_good(7'h2A);
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_word  = words[k];
      r = in_ready;
      tick();
      if (r) begin
        exp_q.push_back(words[k][9:3]);
        k++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (k != 4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_accepts: got %0d accepted, in_ready %b, expected 4 and 0", k, in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 7'h00) begin
      n_fail++;
      $display("FAIL backpressure_head: got ov %b data %h, expected 1 00", out_valid, out_data);
    end
    out_ready = 1'b1;
    send_word(words[4]);
    wait_drain();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_checks++;
    if (err_cnt !== '0) begin
      n_fail++;
      $display("FAIL clear_idle: got %0d, expected 0", err_cnt);
    end
    for (int i = 0; i < 300; i++) send_word(mk_bad(7'($urandom_range(0, 127))));
    tick();
    tick();
    n_checks++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: got %0d, expected 255", err_cnt);
    end
    send_word(mk_bad(7'h11));
    clr_cnt = 1'b1;
    n_checks++;
    if (err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pulse: got err_pulse %b, expected 1", err_pulse);
    end
    tick();
    clr_cnt = 1'b0;
    n_checks++;
    if (err_cnt !== '0) begin
      n_fail++;
      $display("FAIL clear_priority: got %0d, expected 0", err_cnt);
    end
    wait_drain();
  endtask

  task automatic test_pointer_wrap();
    int start;
    start = n_out;
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_word(mk_good(7'($urandom_range(0, 127))));
    end
    wait_drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (n_out - start != 20) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d outputs, expected 20", n_out - start);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_word(mk_good(7'h01));
    send_word(mk_good(7'h02));
    send_word(mk_good(7'h03));
    send_word(mk_bad(7'h04));
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset: got ov %b cnt %0d, expected 1 1", out_valid, err_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== '0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got ov %b ir %b cnt %0d ep %b, expected 0 1 0 0",
               out_valid, in_ready, err_cnt, err_pulse);
    end
    out_ready = 1'b1;
    send_word(mk_good(7'h6B));
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single_good();
    test_bad_word();
    test_backpressure();
    test_saturation();
    test_pointer_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
